// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync/DE with selectable polarity,
// active-area coordinates, line/frame strobes and an optional sync/DE delay line.
module vga_timing_gen #(
  parameter int CW       = 11,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int LAT      = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_SYNC_E  = CW'(H_SYNC);
  localparam logic [CW-1:0] V_SYNC_E  = CW'(V_SYNC);
  localparam logic [CW-1:0] H_ACT_S   = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] H_ACT_E   = CW'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [CW-1:0] V_ACT_S   = CW'(V_SYNC + V_BP);
  localparam logic [CW-1:0] V_ACT_E   = CW'(V_SYNC + V_BP + V_ACTIVE);

  logic [CW-1:0] h_cnt_q, h_cnt_d;
  logic [CW-1:0] v_cnt_q, v_cnt_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          line_start_q, frame_start_q;
  logic          h_act, v_act;

  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (ce) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end
  end

  // Decode works on the counter values being sampled, not the incremented ones.
  always_comb begin
    h_act = (h_cnt_q >= H_ACT_S) && (h_cnt_q < H_ACT_E);
    v_act = (v_cnt_q >= V_ACT_S) && (v_cnt_q < V_ACT_E);
    hs_d  = ce ? (h_cnt_q < H_SYNC_E) : hs_q;
    vs_d  = ce ? (v_cnt_q < V_SYNC_E) : vs_q;
    de_d  = ce ? (h_act && v_act)     : de_q;
    x_d   = x_q;
    y_d   = y_q;
    if (ce) begin
      x_d = h_act ? h_cnt_q - H_ACT_S : '0;
      y_d = v_act ? v_cnt_q - V_ACT_S : '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      de_q          <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      de_q          <= de_d;
      x_q           <= x_d;
      y_q           <= y_d;
      // Strobes are reloaded every clk so they drop after one clk even when ce stalls.
      line_start_q  <= ce && (h_cnt_q == '0);
      frame_start_q <= ce && (h_cnt_q == '0) && (v_cnt_q == '0);
    end
  end

  logic hs_dly, vs_dly, de_dly;

  if (LAT == 0) begin : g_no_dly
    assign hs_dly = hs_q;
    assign vs_dly = vs_q;
    assign de_dly = de_q;
  end else begin : g_dly
    logic [2:0] dly_q [LAT];

    // NOTE: the delay line is reset to inactive values so no stale sync or DE
    // leaks out during the first LAT pixels after reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LAT; i++) dly_q[i] <= 3'b000;
      end else if (ce) begin
        dly_q[0] <= {hs_q, vs_q, de_q};
        for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign {hs_dly, vs_dly, de_dly} = dly_q[LAT-1];
  end

  assign hsync       = (HS_POL != 0) ? hs_dly : ~hs_dly;
  assign vsync       = (VS_POL != 0) ? vs_dly : ~vs_dly;
  assign de          = de_dly;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule
